// File: rtl/multdiv_pkg.sv
// Shared definitions for the multicycle signed multiply/divide unit:
// default operand width, iteration counter width and FSM state encoding.
package multdiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/multdiv_div_step.sv
// One restoring-division step: shift in the next dividend bit, then subtract
// the divisor when it fits. Purely combinational.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_i < divisor_i, so shifted < 2*divisor and the MSB of diff is a clean borrow.
    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {1'b0, divisor_i};
    assign q_o     = ~diff[WIDTH];
    assign rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/multdiv_unit.sv
// Multicycle signed multiply/divide: one bit per cycle on magnitudes, sign fixed
// at the final edge. Results land in Hi/Lo with a one-cycle done pulse.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MULT_on,
    input  logic             DIV_on,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             busy,
    output logic             done,
    output logic             dzero
);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d, dzero_q, dzero_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, mul_res;
    logic [WIDTH-1:0]   rem_nx;
    logic               q_bit;
    logic [2*WIDTH-1:0] div_next;
    logic               last;

    assign a_neg = A_in[WIDTH-1];
    assign b_neg = B_in[WIDTH-1];
    assign a_abs = a_neg ? -A_in : A_in;
    assign b_abs = b_neg ? -B_in : B_in;

    // Multiply: work_q = {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, work_q[WIDTH-1:1]};
    assign mul_res  = neg_q ? -mul_next : mul_next;

    // Divide: work_q = {partial remainder, dividend bits shifting out / quotient bits in}.
    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (work_q[2*WIDTH-1:WIDTH]),
        .bit_i     (work_q[WIDTH-1]),
        .divisor_i (opnd_q),
        .rem_o     (rem_nx),
        .q_o       (q_bit)
    );
    assign div_next = {rem_nx, work_q[WIDTH-2:0], q_bit};

    assign last = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        opnd_d  = opnd_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dzero_d = dzero_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (MULT_on) begin
                    work_d  = {{WIDTH{1'b0}}, b_abs};
                    opnd_d  = a_abs;
                    neg_d   = a_neg ^ b_neg;
                    dzero_d = 1'b0;
                    state_d = ST_MULT;
                end else if (DIV_on) begin
                    if (B_in == '0) begin
                        dzero_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        work_d  = {{WIDTH{1'b0}}, a_abs};
                        opnd_d  = b_abs;
                        neg_d   = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        dzero_d = 1'b0;
                        state_d = ST_DIV;
                    end
                end
            end
            ST_MULT: begin
                work_d = mul_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last) begin
                    {hi_d, lo_d} = mul_res;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DIV: begin
                work_d = div_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last) begin
                    lo_d    = neg_q  ? -div_next[WIDTH-1:0]       : div_next[WIDTH-1:0];
                    hi_d    = rneg_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            opnd_q  <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dzero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            opnd_q  <= opnd_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dzero_q <= dzero_d;
        end
    end

    assign Hi    = hi_q;
    assign Lo    = lo_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign dzero = dzero_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Table-driven and randomized checks of multdiv_unit against plain signed arithmetic.
module tb_multdiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MULT_on, DIV_on;
    logic [31:0] A_in, B_in;
    logic [31:0] Hi, Lo;
    logic        busy, done, dzero;

    int checks   = 0;
    int failures = 0;

    multdiv_unit dut (
        .clk     (clk),
        .reset   (reset),
        .MULT_on (MULT_on),
        .DIV_on  (DIV_on),
        .A_in    (A_in),
        .B_in    (B_in),
        .Hi      (Hi),
        .Lo      (Lo),
        .busy    (busy),
        .done    (done),
        .dzero   (dzero)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          m;
        bit          d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          dz;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: full-width signed product, truncating quotient, dividend-signed remainder.
    function automatic void ref_op(input bit m, input logic [31:0] a, input logic [31:0] b,
                                   inout logic [31:0] hi, inout logic [31:0] lo, output bit dz);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (m) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
            dz = 1'b0;
        end else if (b == 32'd0) begin
            dz = 1'b1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
            dz = 1'b0;
        end
    endfunction

    // Issue one start pulse, scramble operands after the start edge, wait for done.
    task automatic do_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt);
        @(negedge clk);
        MULT_on = m; DIV_on = d; A_in = a; B_in = b;
        @(posedge clk); #1;
        lat  = 0;
        bcnt = int'(busy);
        @(negedge clk);
        MULT_on = 1'b0; DIV_on = 1'b0; A_in = $urandom; B_in = $urandom;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            bcnt += int'(busy);
        end
    endtask

    task automatic apply_and_check(input string tag, input bit m, input bit d,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] ehi, input logic [31:0] elo, input bit edz);
        int lat, bcnt;
        do_op(m, d, a, b, lat, bcnt);
        chk({tag, "_latency"}, 32'(lat), edz ? 32'd0 : 32'd32);
        chk({tag, "_busycyc"}, 32'(bcnt), edz ? 32'd1 : 32'd33);
        chk({tag, "_hi"}, Hi, ehi);
        chk({tag, "_lo"}, Lo, elo);
        chk({tag, "_dzero"}, 32'(dzero), 32'(edz));
        @(posedge clk); #1;
        chk({tag, "_done_drop"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_hold"}, {Hi ^ ehi} | {Lo ^ elo}, 32'd0);
    endtask

    initial begin
        logic [31:0] mhi, mlo;
        bit          mdz;
        int          n, dcnt;

        reset = 1'b0; MULT_on = 1'b0; DIV_on = 1'b0; A_in = '0; B_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", Hi, 32'd0);
        chk("rst_lo", Lo, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dzero", 32'(dzero), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        tbl[0] = '{1'b1, 1'b0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 32'd5,          32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 32'd2,          32'd3,        32'd0,        32'd6,        1'b0};
        tbl[4] = '{1'b0, 1'b1, 32'h80000000,   32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 32'h80000000,   32'h80000000, 32'h40000000, 32'd0,        1'b0};
        tbl[6] = '{1'b1, 1'b1, 32'd4,          32'd5,        32'd0,        32'h14,       1'b0};
        tbl[7] = '{1'b0, 1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hE,        1'b0};
        tbl[8] = '{1'b0, 1'b1, 32'd100,        32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 1'b0};
        tbl[9] = '{1'b0, 1'b1, 32'd0,          32'd0,        32'd2,        32'hFFFFFFF2, 1'b1};

        for (int i = 0; i < 10; i++)
            apply_and_check($sformatf("tbl%0d", i), tbl[i].m, tbl[i].d, tbl[i].a, tbl[i].b,
                            tbl[i].hi, tbl[i].lo, tbl[i].dz);

        // Starts during MULT and during DONE are ignored; operands change mid-run.
        @(negedge clk);
        MULT_on = 1'b1; A_in = 32'd9; B_in = 32'hFFFFFFF5;
        @(posedge clk); #1;
        @(negedge clk);
        MULT_on = 1'b0; A_in = 32'd123; B_in = 32'd0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        DIV_on = 1'b1; A_in = 32'd77; B_in = 32'd0;
        @(posedge clk);
        @(negedge clk);
        DIV_on = 1'b0;
        n = 10;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ign_latency", 32'(n), 32'd32);
        chk("ign_hi", Hi, 32'hFFFFFFFF);
        chk("ign_lo", Lo, 32'hFFFFFF9D);
        chk("ign_dzero", 32'(dzero), 32'd0);
        @(negedge clk);
        DIV_on = 1'b1; B_in = 32'd0;
        @(posedge clk); #1;
        chk("ign_done_busy", 32'(busy), 32'd0);
        chk("ign_done_dzero", 32'(dzero), 32'd0);
        @(negedge clk);
        DIV_on = 1'b0;
        dcnt = 0;
        repeat (5) begin
            @(posedge clk); #1;
            dcnt += int'(done);
        end
        chk("ign_no_extra_done", 32'(dcnt), 32'd0);

        // Randomized operations against the arithmetic reference.
        mhi = Hi; mlo = Lo;
        for (int i = 0; i < 30; i++) begin
            bit          m;
            logic [31:0] a, b;
            m = 1'($urandom_range(0, 1));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            if ($urandom_range(0, 5) == 0) a = 32'h80000000;
            ref_op(m, a, b, mhi, mlo, mdz);
            apply_and_check($sformatf("rnd%0d", i), m, !m, a, b, mhi, mlo, mdz);
        end

        // Reset during a divide aborts it with no done afterwards.
        @(negedge clk);
        DIV_on = 1'b1; A_in = 32'd1000; B_in = 32'd3;
        @(posedge clk); #1;
        @(negedge clk);
        DIV_on = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_hi", Hi, 32'd0);
        chk("rstmid_lo", Lo, 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        chk("rstmid_dzero", 32'(dzero), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        dcnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            dcnt += int'(done);
        end
        chk("rstmid_no_done", 32'(dcnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
